// File: rtl/turn_sequencer.sv
// turn_sequencer: two-player artillery turn controller (positions, aim,
// move budget, auto-repeat, fire request, turn alternation).
// In : clk, reset (async, high), frame_tick, start_new_game, left_x,
//      right_x, left_aim, right_aim, shoot_out, shot_done, shot_hit.
// Out: active_player, p0_x, p1_x, p0_aim, p1_aim, fire, state, winner,
//      moves_left, timeout.
// Optional per-turn frame limit: define TURN_TIMEOUT_EN.
module turn_sequencer #(
  parameter int X_W           = 8,
  parameter int AIM_W         = 4,
  parameter int X_MIN         = 4,
  parameter int X_MAX         = 251,
  parameter int P0_START      = 32,
  parameter int P1_START      = 223,
  parameter int MOVE_BUDGET   = 16,
  parameter int REPEAT_FRAMES = 4,
  parameter int TURN_FRAMES   = 600
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             start_new_game,
  input  logic             left_x,
  input  logic             right_x,
  input  logic             left_aim,
  input  logic             right_aim,
  input  logic             shoot_out,
  input  logic             shot_done,
  input  logic             shot_hit,
  output logic             active_player,
  output logic [X_W-1:0]   p0_x,
  output logic [X_W-1:0]   p1_x,
  output logic [AIM_W-1:0] p0_aim,
  output logic [AIM_W-1:0] p1_aim,
  output logic             fire,
  output logic [1:0]       state,
  output logic             winner,
  output logic [4:0]       moves_left,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TURN   = 2'd1,
    FLIGHT = 2'd2,
    OVER   = 2'd3
  } st_t;

  localparam logic [X_W-1:0]   XLO     = X_W'(X_MIN);
  localparam logic [X_W-1:0]   XHI     = X_W'(X_MAX);
  localparam logic [X_W-1:0]   X0_INIT = X_W'(P0_START);
  localparam logic [X_W-1:0]   X1_INIT = X_W'(P1_START);
  localparam logic [AIM_W-1:0] AIM_MID = {1'b1, {(AIM_W-1){1'b0}}};
  localparam logic [AIM_W-1:0] AIM_MAX = '1;
  localparam logic [4:0]       BUDGET  = 5'(MOVE_BUDGET);
  localparam logic [3:0]       RPT_LD  = 4'(REPEAT_FRAMES - 1);

  st_t              st_q, st_d;
  logic             act_q, act_d;
  logic [X_W-1:0]   x0_q, x0_d, x1_q, x1_d;
  logic [AIM_W-1:0] a0_q, a0_d, a1_q, a1_d;
  logic             fire_q, fire_d;
  logic             win_q, win_d;
  logic [4:0]       mv_q, mv_d;
  logic             tmo_q, tmo_d;
  logic [3:0]       rpt_q, rpt_d;
  logic             shp_q;

  logic             dir, step, turn_new, tmo_hit;
  logic [X_W-1:0]   cur_x, nx;
  logic [AIM_W-1:0] cur_a, na;

  assign dir   = left_x | right_x | left_aim | right_aim;
  assign cur_x = act_q ? x1_q : x0_q;
  assign cur_a = act_q ? a1_q : a0_q;

`ifdef TURN_TIMEOUT_EN
  logic [9:0] tcnt_q, tcnt_d;

  assign tmo_hit = (st_q == TURN) && frame_tick &&
                   (tcnt_q == 10'(TURN_FRAMES - 1));

  always_comb begin
    tcnt_d = tcnt_q;
    if (turn_new)
      tcnt_d = '0;
    else if (st_q == TURN && frame_tick)
      tcnt_d = tcnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tcnt_q <= '0;
    else       tcnt_q <= tcnt_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = turn_new ^ (TURN_FRAMES == 0);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    st_d     = st_q;
    act_d    = act_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    a0_d     = a0_q;
    a1_d     = a1_q;
    fire_d   = 1'b0;
    win_d    = win_q;
    mv_d     = mv_q;
    tmo_d    = 1'b0;
    rpt_d    = rpt_q;
    turn_new = 1'b0;
    step     = 1'b0;
    nx       = cur_x;
    na       = cur_a;
    if (start_new_game) begin
      st_d     = TURN;
      act_d    = 1'b0;
      win_d    = 1'b0;
      x0_d     = X0_INIT;
      x1_d     = X1_INIT;
      a0_d     = AIM_MID;
      a1_d     = AIM_MID;
      mv_d     = BUDGET;
      rpt_d    = '0;
      turn_new = 1'b1;
    end else begin
      unique case (st_q)
        IDLE: rpt_d = '0;
        TURN: begin
          if (shoot_out && !shp_q) begin
            // shoot edge outranks a coincident timeout
            fire_d = 1'b1;
            st_d   = FLIGHT;
            rpt_d  = '0;
          end else if (tmo_hit) begin
            tmo_d    = 1'b1;
            act_d    = ~act_q;
            mv_d     = BUDGET;
            rpt_d    = '0;
            turn_new = 1'b1;
          end else begin
            if (!dir)
              rpt_d = '0;
            else if (frame_tick) begin
              if (rpt_q == '0) begin
                step  = 1'b1;
                rpt_d = RPT_LD;
              end else
                rpt_d = rpt_q - 1'b1;
            end
            if (step) begin
              unique case (1'b1)
                left_x:
                  if (mv_q != '0) begin
                    nx   = (cur_x <= XLO) ? XLO : cur_x - 1'b1;
                    mv_d = mv_q - 1'b1;
                  end
                right_x:
                  if (mv_q != '0) begin
                    nx   = (cur_x >= XHI) ? XHI : cur_x + 1'b1;
                    mv_d = mv_q - 1'b1;
                  end
                left_aim:
                  na = (cur_a == '0) ? '0 : cur_a - 1'b1;
                right_aim:
                  na = (cur_a == AIM_MAX) ? AIM_MAX : cur_a + 1'b1;
                default: ;
              endcase
              if (act_q) begin
                x1_d = nx;
                a1_d = na;
              end else begin
                x0_d = nx;
                a0_d = na;
              end
            end
          end
        end
        FLIGHT: begin
          rpt_d = '0;
          if (shot_done) begin
            if (shot_hit) begin
              st_d  = OVER;
              win_d = act_q;
            end else begin
              st_d     = TURN;
              act_d    = ~act_q;
              mv_d     = BUDGET;
              turn_new = 1'b1;
            end
          end
        end
        OVER: rpt_d = '0;
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= IDLE;
      act_q  <= 1'b0;
      x0_q   <= X0_INIT;
      x1_q   <= X1_INIT;
      a0_q   <= AIM_MID;
      a1_q   <= AIM_MID;
      fire_q <= 1'b0;
      win_q  <= 1'b0;
      mv_q   <= BUDGET;
      tmo_q  <= 1'b0;
      rpt_q  <= '0;
      shp_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      act_q  <= act_d;
      x0_q   <= x0_d;
      x1_q   <= x1_d;
      a0_q   <= a0_d;
      a1_q   <= a1_d;
      fire_q <= fire_d;
      win_q  <= win_d;
      mv_q   <= mv_d;
      tmo_q  <= tmo_d;
      rpt_q  <= rpt_d;
      shp_q  <= shoot_out;
    end
  end

  assign state         = st_q;
  assign active_player = act_q;
  assign p0_x          = x0_q;
  assign p1_x          = x1_q;
  assign p0_aim        = a0_q;
  assign p1_aim        = a1_q;
  assign fire          = fire_q;
  assign winner        = win_q;
  assign moves_left    = mv_q;
  assign timeout       = tmo_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: directed game script plus random button traffic,
// checked every cycle against a behavioural game model.
module tb_turn_sequencer;

  localparam int XMIN = 4, XMAX = 251, P0S = 32, P1S = 223;
  localparam int AMAX = 15, AMID = 8, BUD = 16, RPT = 4, TF = 600;
`ifdef TURN_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, frame_tick, start_new_game;
  logic left_x, right_x, left_aim, right_aim, shoot_out;
  logic shot_done, shot_hit;
  logic       active_player, fire, winner, timeout;
  logic [7:0] p0_x, p1_x;
  logic [3:0] p0_aim, p1_aim;
  logic [1:0] state;
  logic [4:0] moves_left;

  int n_chk = 0;
  int n_err = 0;

  // model state: 0 idle, 1 turn, 2 flight, 3 over
  int m_st, m_act, m_fire, m_win, m_mv, m_tmo, m_cool, m_shp, m_tcnt;
  int m_x[2];
  int m_aim[2];

  turn_sequencer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .start_new_game(start_new_game),
    .left_x(left_x), .right_x(right_x),
    .left_aim(left_aim), .right_aim(right_aim),
    .shoot_out(shoot_out), .shot_done(shot_done), .shot_hit(shot_hit),
    .active_player(active_player), .p0_x(p0_x), .p1_x(p1_x),
    .p0_aim(p0_aim), .p1_aim(p1_aim), .fire(fire), .state(state),
    .winner(winner), .moves_left(moves_left), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_act = 0; m_fire = 0; m_win = 0; m_mv = BUD; m_tmo = 0;
    m_cool = 0; m_shp = 0; m_tcnt = 0;
    m_x[0] = P0S; m_x[1] = P1S; m_aim[0] = AMID; m_aim[1] = AMID;
  endtask

  task automatic pass_turn();
    m_act = 1 - m_act; m_mv = BUD; m_tcnt = 0;
  endtask

  task automatic model_step();
    bit press, held;
    press = shoot_out && (m_shp == 0);
    held  = left_x || right_x || left_aim || right_aim;
    m_shp = shoot_out;
    m_fire = 0; m_tmo = 0;
    if (start_new_game) begin
      m_st = 1; m_act = 0; m_win = 0; m_mv = BUD; m_cool = 0; m_tcnt = 0;
      m_x[0] = P0S; m_x[1] = P1S; m_aim[0] = AMID; m_aim[1] = AMID;
    end else if (m_st == 1) begin
      if (press) begin
        m_fire = 1; m_st = 2; m_cool = 0;
      end else if (TMO_EN && frame_tick && m_tcnt == TF - 1) begin
        m_tmo = 1; m_cool = 0; pass_turn();
      end else begin
        if (frame_tick) m_tcnt++;
        if (!held) m_cool = 0;
        else if (frame_tick && m_cool > 0) m_cool--;
        else if (frame_tick) begin
          m_cool = RPT - 1;
          if ((left_x || right_x) && m_mv > 0) begin
            m_x[m_act] = clamp(m_x[m_act] + (right_x ? 1 : -1), XMIN, XMAX);
            m_mv--;
          end
          if (left_aim || right_aim)
            m_aim[m_act] = clamp(m_aim[m_act] + (right_aim ? 1 : -1), 0, AMAX);
        end
      end
    end else begin
      m_cool = 0;
      if (m_st == 2 && shot_done) begin
        if (shot_hit) begin
          m_st = 3; m_win = m_act;
        end else begin
          m_st = 1; pass_turn();
        end
      end
    end
  endtask

  task automatic check_all();
    check("state", state, m_st);
    check("active_player", active_player, m_act);
    check("p0_x", p0_x, m_x[0]);
    check("p1_x", p1_x, m_x[1]);
    check("p0_aim", p0_aim, m_aim[0]);
    check("p1_aim", p1_aim, m_aim[1]);
    check("fire", fire, m_fire);
    check("winner", winner, m_win);
    check("moves_left", moves_left, m_mv);
    check("timeout", timeout, m_tmo);
  endtask

  task automatic cyc();
    if (reset) model_reset();
    else       model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic frames(int n);
    repeat (n) begin
      frame_tick = 1'b1; cyc();
      frame_tick = 1'b0; cyc(); cyc();
    end
  endtask

  task automatic new_game();
    start_new_game = 1'b1; cyc(); start_new_game = 1'b0;
  endtask

  task automatic set_btn(int b);
    left_x    = (b == 1);
    right_x   = (b == 2);
    left_aim  = (b == 3);
    right_aim = (b == 4);
    shoot_out = (b == 5);
  endtask

  initial begin
    int btn, hold, tmo_seen, fire_seen;
    reset = 1'b1; frame_tick = 1'b0; start_new_game = 1'b0;
    shot_done = 1'b0; shot_hit = 1'b0;
    set_btn(0);
    model_reset();
    #1;
    cyc();
    check("rst_state", state, 0);
    check("rst_p0_x", p0_x, 32);
    check("rst_p1_aim", p1_aim, 8);
    check("rst_moves", moves_left, 16);
    reset = 1'b0;
    cyc();

    new_game();
    check("ng_state", state, 1);
    check("ng_p1_x", p1_x, 223);
    check("ng_aim", p0_aim, 8);
    check("ng_moves", moves_left, 16);

    set_btn(2); frames(9); set_btn(0); cyc();
    check("rep_p0_x", p0_x, 35);
    check("rep_moves", moves_left, 13);

    new_game();
    set_btn(1); frames(72); set_btn(0); cyc();
    check("drain_p0_x", p0_x, 16);
    check("drain_moves", moves_left, 0);
    set_btn(3); frames(48); set_btn(0); cyc();
    check("aim_floor", p0_aim, 0);

    set_btn(5); cyc();
    check("fire_pulse", fire, 1);
    check("fire_state", state, 2);
    cyc();
    check("fire_once", fire, 0);
    shot_done = 1'b1; cyc(); shot_done = 1'b0;
    check("miss_player", active_player, 1);
    check("miss_moves", moves_left, 16);
    repeat (5) cyc();
    check("held_no_fire", state, 1);

    set_btn(0); cyc();
    set_btn(5); cyc(); set_btn(0);
    check("p1_fire", fire, 1);
    shot_done = 1'b1; shot_hit = 1'b1; cyc();
    shot_done = 1'b0; shot_hit = 1'b0;
    check("over_state", state, 3);
    check("over_winner", winner, 1);
    set_btn(2); frames(4); set_btn(0);
    check("over_frozen", p1_x, 223);
    new_game();
    check("ng2_state", state, 1);
    check("ng2_winner", winner, 0);
    check("ng2_p0_x", p0_x, 32);

    set_btn(5); cyc(); set_btn(0);
    check("pre_rst_flight", state, 2);
    reset = 1'b1; cyc(); reset = 1'b0;
    check("rst_flight", state, 0);
    shot_done = 1'b1; cyc(); shot_done = 1'b0;
    check("done_in_idle", state, 0);

    if (TMO_EN) begin
      new_game();
      tmo_seen = 0; fire_seen = 0;
      frame_tick = 1'b1;
      repeat (TF) begin
        cyc();
        tmo_seen += int'(timeout);
        fire_seen += int'(fire);
      end
      frame_tick = 1'b0;
      check("tmo_count", tmo_seen, 1);
      check("tmo_player", active_player, 1);
      check("tmo_no_fire", fire_seen, 0);
    end

    new_game();
    btn = 0; hold = 0;
    repeat (3000) begin
      if (hold == 0) begin
        btn = $urandom_range(0, 5);
        hold = $urandom_range(1, 30);
      end
      hold--;
      set_btn(btn);
      frame_tick     = ($urandom_range(0, 2) == 0);
      shot_done      = ($urandom_range(0, 15) == 0);
      shot_hit       = ($urandom_range(0, 3) == 0);
      start_new_game = ($urandom_range(0, 400) == 0);
      reset          = ($urandom_range(0, 1500) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/turn_sequencer.md
# turn_sequencer

Game-level turn controller for the two-player artillery game. It consumes the one-hot, conflict-filtered button levels from the input-conditioning stage and owns per-player position and aim registers. It enforces per-turn move budgets and auto-repeat pacing, issues the fire request, and alternates turns based on projectile results from the shot engine.

## Interface
- `X_W`, 8: width of player x position.
- `AIM_W`, 4: width of aim angle index.
- `X_MIN` / `X_MAX`, 4 / 251: x saturation bounds (inclusive).
- `P0_START` / `P1_START`, 32 / 223: x positions loaded at reset and at new game.
- `MOVE_BUDGET`, 16: x steps allowed per turn; 5-bit counter.
- `REPEAT_FRAMES`, 4: frames between repeated steps while a button is held; range 1..15.
- `TURN_FRAMES`, 600: turn timeout in frames; used only with the macro; 10-bit counter.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse once per video frame.
- `start_new_game` in 1: level; restart request.
- `left_x`, `right_x`, `left_aim`, `right_aim`, `shoot_out` in 1 each: conditioned button levels, at most one high.
- `shot_done` in 1: one-cycle pulse; the projectile has resolved.
- `shot_hit` in 1: qualifies `shot_done`; 1 = opponent hit.
- `active_player` out 1: player whose turn it is.
- `p0_x`, `p1_x` out X_W: player positions.
- `p0_aim`, `p1_aim` out AIM_W: player aim indices.
- `fire` out 1: one-cycle launch pulse to the shot engine.
- `state` out 2: IDLE=0, TURN=1, FLIGHT=2, OVER=3.
- `winner` out 1: valid in OVER.
- `moves_left` out 5: remaining budget for the active player.
- `timeout` out 1: one-cycle pulse when a turn expires; tied 0 without the macro.

## Operation
- Reset values:
  - state = IDLE; active_player = 0.
  - p0_x = P0_START; p1_x = P1_START; both aims = 2^(AIM_W-1).
  - fire = 0; winner = 0; timeout = 0; moves_left = MOVE_BUDGET.
  - Internal registers: repeat counter = 0, shoot_prev = 0, turn counter = 0.
- `start_new_game` high, in any state, has top priority:
  - Reload positions, aims and budget.
  - Set active_player = 0 and winner = 0.
  - Enter TURN on the next cycle.
- IDLE: waits for `start_new_game`; all other inputs are ignored.
- TURN, step rule (x and aim):
  - A step occurs on a clk where `frame_tick`=1, a direction input is high, and the repeat counter is 0.
  - On a step, the repeat counter reloads to REPEAT_FRAMES-1.
  - On a `frame_tick` with a direction input held and counter ≠ 0, the counter decrements.
  - With no direction input high, the counter clears to 0 on the next clk, so a new press acts on its first frame_tick.
- TURN, x steps:
  - `left_x` gives x-1; `right_x` gives x+1. Saturate at X_MIN/X_MAX.
  - Each step costs 1 budget, including a saturated step.
  - With moves_left = 0, x steps are ignored.
- TURN, aim steps: `left_aim` gives aim-1; `right_aim` gives aim+1. Saturate at 0 and 2^AIM_W-1. Aim steps have no budget cost.
- TURN, firing:
  - A rising edge of `shoot_out` (shoot_out=1, shoot_prev=0) pulses `fire` for one cycle and moves to FLIGHT.
  - shoot_prev samples `shoot_out` every cycle in every state. A shoot held across a turn change therefore never fires; a fresh press is required.
- FLIGHT: controls are ignored. On `shot_done`:
  - `shot_hit`=1: go to OVER with winner = active_player.
  - `shot_hit`=0: toggle active_player, reload moves_left = MOVE_BUDGET, go to TURN.
- `shot_done` outside FLIGHT is ignored.
- OVER: positions are frozen; only `start_new_game` exits.

## Timing
- All outputs are registered; every input effect appears one clk after sampling.
- `fire` is high for exactly the cycle after the rising-edge sample. `state` reads FLIGHT in that same cycle.
- `shot_done` in FLIGHT takes effect on the next cycle (state, active_player, moves_left).
- A step updates on the clk after its frame_tick. Held-button rate is one step per REPEAT_FRAMES frames.
- `reset` asserted mid-FLIGHT clears everything immediately. A subsequent `shot_done` is ignored in IDLE.

## Configuration
- `TURN_TIMEOUT_EN` defined:
  - The turn counter clears on TURN entry and increments on each `frame_tick` in TURN.
  - When the counter reaches TURN_FRAMES-1 and a frame_tick arrives, the turn passes: `timeout` pulses one cycle, active_player toggles, the budget reloads, and no `fire` occurs.
  - A shoot edge in that same cycle takes priority over the timeout.
- `TURN_TIMEOUT_EN` not defined: no turn counter; `timeout` is constant 0; turns are unlimited.

## Test plan
- Reset, then `start_new_game` for 1 cycle → state=1, p0_x=32, p1_x=223, aims=8, moves_left=16, active_player=0.
- `right_x` held for 9 frames, REPEAT_FRAMES=4 → steps on frames 1, 5, 9; p0_x=35, moves_left=13.
- Budget drain: hold `left_x` for 16+ steps → moves_left=0 and p0_x=16; further steps leave p0_x=16. `left_aim` held 12 steps → p0_aim saturates at 0.
- `shoot_out` rises → `fire` high exactly 1 cycle, state=2. `shot_done` with hit=0 → active_player=1, moves_left=16. `shoot_out` still held → no fire.
- Player 1 fires, then `shot_done` with hit=1 → state=3, winner=1. Controls are ignored. `start_new_game` → state=1, winner=0, positions reloaded.
- With `TURN_TIMEOUT_EN`, TURN_FRAMES=600 and no input for 600 frames → `timeout` pulses once, active_player toggles, `fire` stays 0.
